uart_axi_debug_master: RTL and testbench
========================================

# uart_axi_debug_master

Byte-stream command decoder that acts as an AXI4-lite master (initiator) on the SoC interconnect. The block sits between a UART byte receiver/transmitter pair and the AXI4-lite fabric, giving a host PC read/write access to any slave, including the simpleuart register adapter. Each received command frame becomes exactly one AXI4-lite transaction, and the result goes back as bytes.

## Interface
- GAP_TIMEOUT, 100000 — maximum clk cycles allowed between two bytes of one frame before the frame is discarded; counter width is $clog2(GAP_TIMEOUT+1).
- ACK_BYTE, 8'h4B — byte returned after a completed write.
- NAK_BYTE, 8'h3F — byte returned for an unknown command byte.
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts rx_data; a byte transfers when rx_valid && rx_ready.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts; a byte transfers when tx_valid && tx_ready.
- mem_axi_awvalid / awready / awaddr[31:0] / awprot[2:0]  out/in/out/out — write address channel.
- mem_axi_wvalid / wready / wdata[31:0] / wstrb[3:0]  out/in/out/out — write data channel.
- mem_axi_bvalid / bready  in/out — write response; no bresp.
- mem_axi_arvalid / arready / araddr[31:0] / arprot[2:0]  out/in/out/out — read address channel.
- mem_axi_rvalid / rready / rdata[31:0]  in/out/in — read data; no rresp.
- busy  out  1  high in every state except IDLE.

## Operation
- Frame formats:
  - Write: 8'h57 ('W'), then addr[7:0], addr[15:8], addr[23:16], addr[31:24], then data bytes in the same little-endian order.
  - Read: 8'h52 ('R'), then 4 address bytes, little-endian.
- Any other first byte → NAK_BYTE is queued; no AXI activity.
- Fixed field values: awaddr/araddr[1:0] forced to 2'b00. wstrb = 4'hF. awprot = arprot = 3'b000.
- FSM states: IDLE, ADDR, DATA, WR_REQ, B_WAIT, RD_REQ, R_WAIT, TX.
  - IDLE: rx_ready=1. 'W' or 'R' → ADDR with byte count 0. Other byte → TX with 1 byte (NAK_BYTE).
  - ADDR: rx_ready=1. Shift bytes into the address register. After the 4th byte: 'W' → DATA, 'R' → RD_REQ.
  - DATA: rx_ready=1. After the 4th byte → WR_REQ.
  - WR_REQ: awvalid=wvalid=1 on entry. Each valid drops on the cycle after its own ready is sampled high. Both handshakes done → B_WAIT. The two channels are independent, in any order or simultaneous.
  - B_WAIT: bready=1. On bvalid → TX with 1 byte (ACK_BYTE).
  - RD_REQ: arvalid=1 until arready is sampled, then → R_WAIT.
  - R_WAIT: rready=1. On rvalid, capture rdata → TX with 4 bytes, LSB first.
  - TX: tx_valid=1; tx_data is stable until the handshake. Advance the byte index on each handshake. After the last byte → IDLE.
- rx_ready=0 in WR_REQ, B_WAIT, RD_REQ, R_WAIT and TX. Bytes are not dropped there; they are back-pressured.
- Gap timeout (ADDR/DATA only):
  - The counter clears on each accepted byte and increments otherwise.
  - Reaching GAP_TIMEOUT → IDLE, partial frame discarded, no response byte.
- Issued AXI transactions have no timeout. The block waits indefinitely for ready/bvalid/rvalid.

## Timing
- Reset values:
  - rx_ready=0; it goes to 1 on the first clk edge after resetn deasserts.
  - tx_valid=0, tx_data=0.
  - All AXI valid/ready outputs = 0; awaddr/araddr/wdata = 0.
  - busy=0, state=IDLE, all counters 0.
- All outputs are registered.
- Issue latency: awvalid/wvalid (or arvalid) rise 1 cycle after the last frame byte is accepted.
- Response latency:
  - tx_valid rises 1 cycle after the bvalid or rvalid handshake.
  - The captured rdata equals rdata sampled in the handshake cycle.
- A byte accepted by rx is never also processed in the same cycle as a state exit.
- awaddr, wdata and araddr hold stable from valid assertion until their handshake.
- Reset mid-operation: all valids drop asynchronously; any in-flight AXI transaction is abandoned and not replayed.

## Test plan
- Write round-trip:
  - Stimulus: rx 57 08 80 01 00 A5 00 00 00; awready/wready high.
  - Required: one AW beat with awaddr=32'h00018008; one W beat with wdata=32'h000000A5, wstrb=F.
  - After bvalid: tx 4B only, then busy=0.
- Read round-trip:
  - Stimulus: rx 52 04 80 01 00; slave returns rdata=32'h12345678 after 5 cycles.
  - Required: araddr=32'h00018004; tx 78 56 34 12, in that order.
- Skewed write handshakes:
  - Stimulus: wready=1 immediately, awready delayed 3 cycles, bvalid 2 cycles later.
  - Required: wvalid lasts 1 cycle, awvalid lasts 4 cycles, bready is high only after both; ACK follows.
- Bad command plus backpressure:
  - Stimulus: rx 00, tx_ready=0 for 10 cycles.
  - Required: tx_valid=1 with tx_data=3F stable for all 10 cycles; rx_ready=0 until the byte is sent; no AXI valids.
- Gap timeout:
  - Stimulus: rx 57 10 20, then idle for GAP_TIMEOUT cycles, then a full read frame.
  - Required: no AW/W activity; the read completes normally with 4 tx bytes.
- Reset in B_WAIT:
  - Stimulus: assert resetn=0 mid-B_WAIT.
  - Required: bready/tx_valid are 0 immediately; after release, a new write frame completes with ACK.

Source files
------------

// File: rtl/uart_axi_debug_master_if.sv
// AXI4-lite bundle between the UART debug master and the interconnect.
// Write response and read data carry no resp fields.
interface uart_axi_debug_master_if;
  // Write address channel
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  // Write data channel
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  // Write response channel
  logic        bvalid;
  logic        bready;
  // Read address channel
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  // Read data channel
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata,
    input  rready
  );
endinterface

// File: rtl/uart_axi_debug_master.sv
// UART byte-stream command decoder acting as an AXI4-lite master.
// 'W' + 4 addr bytes + 4 data bytes -> one write, answered with ACK_BYTE.
// 'R' + 4 addr bytes               -> one read, answered with 4 data bytes LSB first.
// Any other leading byte is answered with NAK_BYTE. Every output is a register.
module uart_axi_debug_master #(
  parameter int unsigned GAP_TIMEOUT = 100000,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B,
  parameter logic [7:0]  NAK_BYTE    = 8'h3F
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic                            rx_ready,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  uart_axi_debug_master_if.master         mem_axi,
  output logic                            busy
);

  localparam int         GAP_W     = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WR_REQ, B_WAIT, RD_REQ, R_WAIT, TX
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic              is_write_reg, is_write_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              awvalid_reg, awvalid_next;
  logic              wvalid_reg, wvalid_next;
  logic              aw_done_reg, aw_done_next;
  logic              w_done_reg, w_done_next;
  logic              bready_reg, bready_next;
  logic              arvalid_reg, arvalid_next;
  logic              rready_reg, rready_next;
  logic              rx_ready_reg, rx_ready_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic [31:0]       tx_shift_reg, tx_shift_next;
  logic [2:0]        tx_left_reg, tx_left_next;
  logic              busy_reg, busy_next;

  logic rx_fire, tx_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [GAP_W-1:0] gap_inc;

  assign rx_fire = rx_valid && rx_ready_reg;
  assign tx_fire = tx_valid_reg && tx_ready;
  assign aw_fire = awvalid_reg && mem_axi.awready;
  assign w_fire  = wvalid_reg && mem_axi.wready;
  assign b_fire  = bready_reg && mem_axi.bvalid;
  assign ar_fire = arvalid_reg && mem_axi.arready;
  assign r_fire  = rready_reg && mem_axi.rvalid;
  assign gap_inc = gap_cnt_reg + GAP_W'(1);

  // State and every output register; reset drops all valids immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      awvalid_reg  <= 1'b0;
      wvalid_reg   <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      bready_reg   <= 1'b0;
      arvalid_reg  <= 1'b0;
      rready_reg   <= 1'b0;
      rx_ready_reg <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_shift_reg <= '0;
      tx_left_reg  <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      is_write_reg <= is_write_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      awvalid_reg  <= awvalid_next;
      wvalid_reg   <= wvalid_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
      bready_reg   <= bready_next;
      arvalid_reg  <= arvalid_next;
      rready_reg   <= rready_next;
      rx_ready_reg <= rx_ready_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      tx_shift_reg <= tx_shift_next;
      tx_left_reg  <= tx_left_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state and next-output decode; outputs are derived from the next state
  // so that they appear registered in the same cycle the state changes
  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    is_write_next = is_write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    awvalid_next  = awvalid_reg;
    wvalid_next   = wvalid_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    bready_next   = bready_reg;
    arvalid_next  = arvalid_reg;
    rready_next   = rready_reg;
    tx_valid_next = tx_valid_reg;
    tx_data_next  = tx_data_reg;
    tx_shift_next = tx_shift_reg;
    tx_left_next  = tx_left_reg;

    case (state_reg)
      IDLE: begin
        if (rx_fire) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            is_write_next = (rx_data == CMD_WRITE);
            byte_cnt_next = '0;
            gap_cnt_next  = '0;
            state_next    = ADDR;
          end else begin
            tx_data_next  = NAK_BYTE;
            tx_left_next  = 3'd1;
            tx_valid_next = 1'b1;
            state_next    = TX;
          end
        end
      end

      ADDR: begin
        if (rx_fire) begin
          // Little-endian: first byte ends up in addr[7:0]
          addr_next     = {rx_data, addr_reg[31:8]};
          gap_cnt_next  = '0;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            if (is_write_reg) begin
              state_next = DATA;
            end else begin
              arvalid_next = 1'b1;
              state_next   = RD_REQ;
            end
          end
        end else if (gap_inc == GAP_LIMIT) begin
          gap_cnt_next  = '0;
          byte_cnt_next = '0;
          state_next    = IDLE;
        end else begin
          gap_cnt_next = gap_inc;
        end
      end

      DATA: begin
        if (rx_fire) begin
          wdata_next    = {rx_data, wdata_reg[31:8]};
          gap_cnt_next  = '0;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = WR_REQ;
          end
        end else if (gap_inc == GAP_LIMIT) begin
          gap_cnt_next  = '0;
          byte_cnt_next = '0;
          state_next    = IDLE;
        end else begin
          gap_cnt_next = gap_inc;
        end
      end

      WR_REQ: begin
        // AW and W complete independently; wait for both before the response
        if (aw_fire) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (w_fire) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
          bready_next = 1'b1;
          state_next  = B_WAIT;
        end
      end

      B_WAIT: begin
        if (b_fire) begin
          bready_next   = 1'b0;
          tx_data_next  = ACK_BYTE;
          tx_left_next  = 3'd1;
          tx_valid_next = 1'b1;
          state_next    = TX;
        end
      end

      RD_REQ: begin
        if (ar_fire) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = R_WAIT;
        end
      end

      R_WAIT: begin
        if (r_fire) begin
          rready_next   = 1'b0;
          tx_shift_next = mem_axi.rdata;
          tx_data_next  = mem_axi.rdata[7:0];
          tx_left_next  = 3'd4;
          tx_valid_next = 1'b1;
          state_next    = TX;
        end
      end

      TX: begin
        // tx_data only moves on a handshake, so it is stable under backpressure
        if (tx_fire) begin
          if (tx_left_reg == 3'd1) begin
            tx_valid_next = 1'b0;
            tx_left_next  = '0;
            state_next    = IDLE;
          end else begin
            tx_data_next  = tx_shift_reg[15:8];
            tx_shift_next = {8'h00, tx_shift_reg[31:8]};
            tx_left_next  = tx_left_reg - 3'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    rx_ready_next = (state_next == IDLE) || (state_next == ADDR) || (state_next == DATA);
    busy_next     = (state_next != IDLE);
  end

  assign rx_ready        = rx_ready_reg;
  assign tx_valid        = tx_valid_reg;
  assign tx_data         = tx_data_reg;
  assign busy            = busy_reg;

  assign mem_axi.awvalid = awvalid_reg;
  assign mem_axi.awaddr  = {addr_reg[31:2], 2'b00};
  assign mem_axi.awprot  = 3'b000;
  assign mem_axi.wvalid  = wvalid_reg;
  assign mem_axi.wdata   = wdata_reg;
  assign mem_axi.wstrb   = 4'hF;
  assign mem_axi.bready  = bready_reg;
  assign mem_axi.arvalid = arvalid_reg;
  assign mem_axi.araddr  = {addr_reg[31:2], 2'b00};
  assign mem_axi.arprot  = 3'b000;
  assign mem_axi.rready  = rready_reg;

endmodule

// File: tb/tb_uart_axi_debug_master.sv
// Self-checking bench for uart_axi_debug_master: directed frames from the test
// plan plus randomized frames, compared against a frame-level reference model.
module tb_uart_axi_debug_master;

  localparam int         GAP = 40;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h3F;

  logic       clk;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  uart_axi_debug_master_if mem_axi ();

  uart_axi_debug_master #(
    .GAP_TIMEOUT(GAP),
    .ACK_BYTE   (ACK),
    .NAK_BYTE   (NAK)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .mem_axi (mem_axi),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // ---------------- bus monitor (mid-cycle, all signals stable) ----------------
  int unsigned cyc = 0;
  logic [34:0] aw_log[$];
  logic [35:0] w_log[$];
  logic [34:0] ar_log[$];
  logic [7:0]  tx_log[$];
  int          aw_hi = 0;
  int          w_hi  = 0;
  int unsigned aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, r_hs_cyc = 0;
  int unsigned bready_rise_cyc = 0, tx_rise_cyc = 0;
  logic        bready_prev = 1'b0;
  logic        tx_valid_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_axi.awvalid === 1'b1) aw_hi++;
      if (mem_axi.wvalid === 1'b1) w_hi++;
      if (mem_axi.awvalid && mem_axi.awready) begin
        aw_log.push_back({mem_axi.awprot, mem_axi.awaddr});
        aw_hs_cyc = cyc;
      end
      if (mem_axi.wvalid && mem_axi.wready) begin
        w_log.push_back({mem_axi.wstrb, mem_axi.wdata});
        w_hs_cyc = cyc;
      end
      if (mem_axi.arvalid && mem_axi.arready) ar_log.push_back({mem_axi.arprot, mem_axi.araddr});
      if (mem_axi.bvalid && mem_axi.bready) b_hs_cyc = cyc;
      if (mem_axi.rvalid && mem_axi.rready) r_hs_cyc = cyc;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (mem_axi.bready && !bready_prev) bready_rise_cyc = cyc;
      if (tx_valid && !tx_valid_prev) tx_rise_cyc = cyc;
      bready_prev   = mem_axi.bready;
      tx_valid_prev = tx_valid;
    end
  end

  // ---------------- AXI slave with programmable delays ----------------
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int          aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  logic [31:0] slave_rdata = 32'h0;

  initial begin
    mem_axi.awready = 1'b0;
    mem_axi.wready  = 1'b0;
    mem_axi.bvalid  = 1'b0;
    mem_axi.arready = 1'b0;
    mem_axi.rvalid  = 1'b0;
    mem_axi.rdata   = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_axi.awvalid) begin
        if (aw_c >= aw_delay) mem_axi.awready = 1'b1;
        else begin mem_axi.awready = 1'b0; aw_c++; end
      end else begin mem_axi.awready = 1'b0; aw_c = 0; end
      if (mem_axi.wvalid) begin
        if (w_c >= w_delay) mem_axi.wready = 1'b1;
        else begin mem_axi.wready = 1'b0; w_c++; end
      end else begin mem_axi.wready = 1'b0; w_c = 0; end
      if (mem_axi.bready) begin
        if (b_c >= b_delay) mem_axi.bvalid = 1'b1;
        else begin mem_axi.bvalid = 1'b0; b_c++; end
      end else begin mem_axi.bvalid = 1'b0; b_c = 0; end
      if (mem_axi.arvalid) begin
        if (ar_c >= ar_delay) mem_axi.arready = 1'b1;
        else begin mem_axi.arready = 1'b0; ar_c++; end
      end else begin mem_axi.arready = 1'b0; ar_c = 0; end
      if (mem_axi.rready) begin
        if (r_c >= r_delay) mem_axi.rvalid = 1'b1;
        else begin mem_axi.rvalid = 1'b0; r_c++; end
      end else begin mem_axi.rvalid = 1'b0; r_c = 0; end
      mem_axi.rdata = mem_axi.rvalid ? slave_rdata : 32'h0BAD_0BAD;
    end
  end

  // ---------------- UART transmitter side ----------------
  bit   tx_rand = 1'b0;
  logic tx_hold = 1'b1;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      tx_ready = tx_rand ? ($urandom_range(0, 1) == 1) : tx_hold;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) step();
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check("rx_accept_timeout", 1, 0);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  // Frame-level model: expected AXI beats and response bytes from the command rules
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int gap_lo, input int gap_hi);
    logic [7:0]  fb[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_addr;
    int          exp_aw, exp_ar, a0, w0, r0, t0;
    bit          is_w, is_r;
    is_w     = (cmd == 8'h57);
    is_r     = (cmd == 8'h52);
    exp_addr = addr & 32'hFFFF_FFFC;
    fb.push_back(cmd);
    if (is_w || is_r) for (int i = 0; i < 4; i++) fb.push_back(8'(addr >> (8 * i)));
    if (is_w) for (int i = 0; i < 4; i++) fb.push_back(8'(data >> (8 * i)));
    if (is_w) exp_tx.push_back(ACK);
    else if (is_r) for (int i = 0; i < 4; i++) exp_tx.push_back(8'(rdata >> (8 * i)));
    else exp_tx.push_back(NAK);
    exp_aw = is_w ? 1 : 0;
    exp_ar = is_r ? 1 : 0;
    slave_rdata = rdata;
    a0 = aw_log.size(); w0 = w_log.size(); r0 = ar_log.size(); t0 = tx_log.size();

    foreach (fb[i]) send_byte(fb[i], (i == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo)));

    if (is_w) check("aw_w_issue", {mem_axi.awvalid, mem_axi.wvalid}, 2'b11);
    else if (is_r) check("ar_issue", mem_axi.arvalid, 1'b1);
    else check("nak_out", {tx_valid, tx_data}, {1'b1, NAK});

    wait_idle();

    check("aw_count", aw_log.size() - a0, exp_aw);
    check("w_count", w_log.size() - w0, exp_aw);
    check("ar_count", ar_log.size() - r0, exp_ar);
    if (is_w && aw_log.size() == a0 + 1) check("awaddr", aw_log[a0], {3'b000, exp_addr});
    if (is_w && w_log.size() == w0 + 1) check("wdata", w_log[w0], {4'hF, data});
    if (is_r && ar_log.size() == r0 + 1) check("araddr", ar_log[r0], {3'b000, exp_addr});
    check("tx_count", tx_log.size() - t0, exp_tx.size());
    foreach (exp_tx[i]) if (t0 + i < tx_log.size()) check("tx_byte", tx_log[t0 + i], exp_tx[i]);
    if (is_w) check("resp_latency_b", tx_rise_cyc - b_hs_cyc, 1);
    if (is_r) check("resp_latency_r", tx_rise_cyc - r_hs_cyc, 1);
    $display("frame cmd=%02h addr=%08h data=%08h rdata=%08h tx_bytes=%0d", cmd, addr, data, rdata,
             tx_log.size() - t0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          aw0, w0, n;
    logic [7:0]  c;
    logic [31:0] rnd;
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx", {tx_valid, tx_data}, 9'h000);
    check("rst_axi_ctrl", {mem_axi.awvalid, mem_axi.wvalid, mem_axi.arvalid, mem_axi.bready, mem_axi.rready}, 5'b0);
    check("rst_busy", busy, 0);
    check("rst_awaddr", mem_axi.awaddr, 32'h0);
    check("rst_araddr", mem_axi.araddr, 32'h0);
    check("rst_wdata", mem_axi.wdata, 32'h0);
    resetn = 1'b1;
    #1;
    check("rx_ready_before_edge", rx_ready, 0);
    step();
    check("rx_ready_after_edge", rx_ready, 1);

    // Write round-trip
    run_frame(8'h57, 32'h0001_8008, 32'h0000_00A5, 32'h0, 0, 0);
    check("busy_after_write", busy, 0);

    // Read round-trip with slow read data
    r_delay = 5;
    run_frame(8'h52, 32'h0001_8004, 32'h0, 32'h1234_5678, 0, 0);
    r_delay = 0;

    // Skewed write handshakes
    aw_delay = 3; w_delay = 0; b_delay = 2;
    aw0 = aw_hi; w0 = w_hi;
    run_frame(8'h57, 32'h0000_0103, $urandom, 32'h0, 0, 0);
    check("awvalid_cycles", aw_hi - aw0, 4);
    check("wvalid_cycles", w_hi - w0, 1);
    check("bready_after_both", (bready_rise_cyc > aw_hs_cyc) && (bready_rise_cyc > w_hs_cyc), 1);
    aw_delay = 0; b_delay = 0;

    // Unknown command under transmit backpressure
    tx_hold = 1'b0;
    n = tx_log.size();
    send_byte(8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      check("nak_hold",
            {tx_valid, tx_data, rx_ready, mem_axi.awvalid, mem_axi.wvalid, mem_axi.arvalid},
            {1'b1, NAK, 1'b0, 3'b000});
      step();
    end
    tx_hold = 1'b1;
    wait_idle();
    check("nak_count", tx_log.size() - n, 1);
    if (tx_log.size() == n + 1) check("nak_byte", tx_log[n], NAK);

    // Gap timeout discards a partial write frame silently
    aw0 = aw_log.size(); w0 = w_log.size(); n = tx_log.size();
    send_byte(8'h57, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    repeat (GAP + 3) step();
    check("gap_busy", busy, 0);
    check("gap_no_aw_w", (aw_log.size() - aw0) + (w_log.size() - w0), 0);
    check("gap_no_tx", tx_log.size() - n, 0);
    run_frame(8'h52, $urandom, 32'h0, $urandom, 0, 0);

    // Gaps just under the timeout keep the frame alive
    run_frame(8'h57, $urandom, $urandom, 32'h0, GAP - 3, GAP - 3);

    // Randomized frames with random slave delays and transmit stalls
    tx_rand = 1'b1;
    for (int k = 0; k < 24; k++) begin
      n = int'($urandom_range(9, 0));
      if (n < 4) c = 8'h57;
      else if (n < 8) c = 8'h52;
      else begin
        c = 8'($urandom_range(255, 0));
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
      end
      aw_delay = int'($urandom_range(4, 0));
      w_delay  = int'($urandom_range(4, 0));
      b_delay  = int'($urandom_range(4, 0));
      ar_delay = int'($urandom_range(4, 0));
      r_delay  = int'($urandom_range(4, 0));
      rnd = $urandom;
      run_frame(c, $urandom, rnd, $urandom, 0, 3);
    end
    tx_rand = 1'b0;
    aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0;

    // Reset while waiting for the write response
    b_delay = 1000;
    n = tx_log.size();
    send_byte(8'h57, 0);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 0);
    for (int i = 0; i < 100 && !mem_axi.bready; i++) step();
    check("bwait_reached", mem_axi.bready, 1);
    resetn = 1'b0;
    #1;
    check("rst_async_bready", mem_axi.bready, 0);
    check("rst_async_tx_valid", tx_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_valids", {mem_axi.awvalid, mem_axi.wvalid, mem_axi.arvalid, rx_ready}, 4'b0);
    step();
    step();
    resetn = 1'b1;
    b_delay = 0;
    step();
    check("no_tx_from_aborted", tx_log.size() - n, 0);
    run_frame(8'h57, 32'hCAFE_0010, 32'hDEAD_BEEF, 32'h0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
